// File: rtl/ql_clkgate_ctl_pkg.sv
// ql_clkgate_pkg: shared state encoding and default timing for the FCB clock-gate controller
package ql_clkgate_pkg;
   typedef enum logic [1:0] {OFF = 2'd0, WAKE = 2'd1, ON = 2'd2, IDLE = 2'd3} cg_state_e;
   localparam int CG_WAKE_CYCLES_DEF = 2;
   localparam int CG_IDLE_CYCLES_DEF = 16;
   localparam int CG_CNT_W_DEF       = 8;
endpackage

// File: rtl/ql_clkgate_ctl_if.sv
// ql_clkgate_ctl_if: request/acknowledge and gate-enable signals between a consumer and the controller
interface ql_clkgate_ctl_if;
   logic req_i;
   logic force_on_i;
   logic ack_o;
   logic cg_en_o;
   logic gated_o;
   modport master (output req_i, force_on_i, input ack_o, cg_en_o, gated_o);
   modport slave  (input req_i, force_on_i, output ack_o, cg_en_o, gated_o);
endinterface

// File: rtl/ql_clkgate_ctl.sv
// ql_clkgate_ctl: opens the clock gate on request, acks after a settle time, closes after an idle window
module ql_clkgate_ctl
   import ql_clkgate_pkg::*;
#(
   parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEF,
   parameter int IDLE_CYCLES = CG_IDLE_CYCLES_DEF,
   parameter int CNT_W       = CG_CNT_W_DEF
) (
   input  logic             fcb_sys_clk,
   input  logic             fcb_sys_rst_n,
   ql_clkgate_ctl_if.slave  cg
);
   if (CNT_W < 1 || CNT_W > 30) begin : g_cnt_w_chk
      $error("ql_clkgate_ctl: CNT_W out of range");
   end
   if (WAKE_CYCLES < 1 || WAKE_CYCLES > (1 << CNT_W) - 1) begin : g_wake_chk
      $error("ql_clkgate_ctl: WAKE_CYCLES out of range");
   end
   if (IDLE_CYCLES < 1 || IDLE_CYCLES > (1 << CNT_W) - 1) begin : g_idle_chk
      $error("ql_clkgate_ctl: IDLE_CYCLES out of range");
   end

   localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);

   cg_state_e        r_state;
   cg_state_e        w_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_want;
   logic             w_cnt_z;
   logic             r_ack;
   logic             r_cg_en;
   logic             r_gated;

   // One down-counter serves both the settle (WAKE) and the idle (IDLE) windows
   always_comb begin
      w_want    = cg.req_i | cg.force_on_i;
      w_cnt_z   = (r_cnt == '0);
      w_nxt     = OFF;
      w_cnt_nxt = r_cnt;
      case (r_state)
         OFF: begin
            w_nxt     = w_want ? WAKE : OFF;
            w_cnt_nxt = w_want ? WAKE_LD : r_cnt;
         end
         WAKE: begin
            w_nxt     = w_cnt_z ? ON : WAKE;
            w_cnt_nxt = w_cnt_z ? r_cnt : r_cnt - 1'b1;
         end
         ON: begin
            w_nxt     = w_want ? ON : IDLE;
            w_cnt_nxt = w_want ? r_cnt : IDLE_LD;
         end
         IDLE: begin
            w_nxt     = w_want ? ON : (w_cnt_z ? OFF : IDLE);
            w_cnt_nxt = (w_want || w_cnt_z) ? r_cnt : r_cnt - 1'b1;
         end
         default: begin
            w_nxt     = OFF;
            w_cnt_nxt = '0;
         end
      endcase
   end

   // Outputs are registered from next-state so the gate enable never glitches
   always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
      if (!fcb_sys_rst_n) begin
         r_state <= OFF;
         r_cnt   <= '0;
         r_ack   <= 1'b0;
         r_cg_en <= 1'b0;
         r_gated <= 1'b1;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= (w_nxt == ON) & cg.req_i;
         r_cg_en <= (w_nxt != OFF);
         r_gated <= (w_nxt == OFF);
      end
   end

   assign cg.ack_o   = r_ack;
   assign cg.cg_en_o = r_cg_en;
   assign cg.gated_o = r_gated;
endmodule

// File: tb/tb_ql_clkgate_ctl.sv
// tb_ql_clkgate_ctl: directed checks of wake, release, re-request, pulse, force and async reset
module tb_ql_clkgate_ctl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_pass = 0;

   ql_clkgate_ctl_if cg ();

   ql_clkgate_ctl u_dut (
      .fcb_sys_clk   (clk),
      .fcb_sys_rst_n (rst_n),
      .cg            (cg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic outs(input string tag, input logic ack, input logic en, input logic gated);
      chk($sformatf("%s_ack", tag), 32'(cg.ack_o), 32'(ack));
      chk($sformatf("%s_en", tag), 32'(cg.cg_en_o), 32'(en));
      chk($sformatf("%s_gated", tag), 32'(cg.gated_o), 32'(gated));
   endtask

   initial begin
      rst_n         = 1'b0;
      cg.req_i      = 1'b1;
      cg.force_on_i = 1'b0;
      repeat (2) @(negedge clk);
      outs("reset", 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         outs($sformatf("wake%0d", i), i >= 3, 1'b1, 1'b0);
      end
      cg.req_i = 1'b0;
      for (int j = 1; j <= 17; j++) begin
         @(negedge clk);
         outs($sformatf("rel%0d", j), 1'b0, j < 17, j == 17);
      end
      cg.req_i = 1'b1;
      repeat (4) @(negedge clk);
      outs("rereq_on", 1'b1, 1'b1, 1'b0);
      cg.req_i = 1'b0;
      for (int j = 1; j <= 11; j++) begin
         @(negedge clk);
         outs($sformatf("rereq_idle%0d", j), 1'b0, 1'b1, 1'b0);
      end
      cg.req_i = 1'b1;
      @(negedge clk);
      outs("rereq_ack", 1'b1, 1'b1, 1'b0);
      cg.req_i = 1'b0;
      repeat (17) @(negedge clk);
      outs("rereq_off", 1'b0, 1'b0, 1'b1);
      cg.req_i = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         cg.req_i = 1'b0;
         outs($sformatf("pulse%0d", i), 1'b0, i < 20, i == 20);
      end
      cg.force_on_i = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         outs($sformatf("force%0d", i), 1'b0, 1'b1, 1'b0);
      end
      cg.force_on_i = 1'b0;
      for (int j = 1; j <= 17; j++) begin
         @(negedge clk);
         outs($sformatf("unforce%0d", j), 1'b0, j < 17, j == 17);
      end
      cg.req_i = 1'b1;
      @(negedge clk);
      outs("mwake_pre", 1'b0, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1 outs("mwake_rst", 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      outs("mon_pre", 1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1 outs("mon_rst", 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      cg.req_i = 1'b0;
      repeat (5) @(negedge clk);
      outs("midle_pre", 1'b0, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1 outs("midle_rst", 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      outs("midle_hold", 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);
      outs("post_rst", 1'b0, 1'b0, 1'b1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
